systolic_pe_acc: RTL and testbench
==================================

// Module: systolic_pe_acc
// PURPOSE
//  Parametrised processing element for the systolic matrix-multiply array.
//  It forwards operands east/south with one register stage and accumulates
//  a*b over a window of K_DEPTH valid beats.
//  At the end of each window the sum moves to a result register and the
//  accumulator restarts, so a drain handshake overlaps the next accumulation.
//  Adds valid tracking, signed mode, saturation and overrun detection.
// PARAMETERS
//  A_WIDTH    8   operand a width
//  B_WIDTH    8   operand b width
//  ACC_WIDTH  24  accumulator / result width (>= A_WIDTH+B_WIDTH)
//  K_DEPTH    4   valid beats per accumulation window (>= 1)
//  SIGNED     0   1: two's-complement operands/acc; 0: unsigned
//  SATURATE   0   1: clamp to ACC_WIDTH range; 0: wrap modulo 2^ACC_WIDTH
// PORTS
//  clock      in   1          single clock, rising edge
//  reset      in   1          asynchronous, active-high
//  clear      in   1          sync: abort window, zero acc/count/overrun
//  in_valid   in   1          a_in/b_in carry a valid beat
//  a_in       in   A_WIDTH    operand a (from west)
//  b_in       in   B_WIDTH    operand b (from north)
//  a_out      out  A_WIDTH    a_in registered 1 cycle (to east)
//  b_out      out  B_WIDTH    b_in registered 1 cycle (to south)
//  out_valid  out  1          in_valid registered 1 cycle
//  res_valid  out  1          res_data holds an undrained window sum
//  res_ready  in   1          consumer accepts res_data this cycle
//  res_data   out  ACC_WIDTH  completed window sum
//  res_sat    out  1          saturation/overflow occurred in res_data window
//  overrun    out  1          sticky: an undrained result was overwritten
// BEHAVIOUR
//  Reset: all outputs, acc, beat count, window-sat flag = 0, immediately.
//  Forwarding: a_out/b_out/out_valid <= inputs every cycle, latency 1.
//   This is independent of clear and of the result state.
//  Product: full A_WIDTH+B_WIDTH bits. Sign- or zero-extended per SIGNED
//   to ACC_WIDTH+1 bits, then added to acc.
//  SATURATE=1: out-of-range sums clamp.
//   Signed range: 2^(W-1)-1 / -2^(W-1). Unsigned range: 2^W-1.
//   The window-sat flag is set.
//  SATURATE=0: the sum wraps. Window-sat is still set on overflow.
//  Beat counter cnt 0..K_DEPTH-1 advances only on in_valid & !clear.
//  Non-final beat: acc <= sum, cnt++.
//  Final beat (cnt==K_DEPTH-1): at the same edge
//   - res_data <= sum; res_sat <= window-sat | this beat's overflow
//   - res_valid <= 1; acc, cnt and window-sat <= 0
//   - result visible the cycle after the K-th beat is sampled
//  K_DEPTH=1: every valid beat yields res_data = product.
//  Result buffer states:
//   EMPTY (res_valid=0) -> FULL on final beat.
//   FULL -> EMPTY on res_ready and no final beat.
//   FULL -> FULL (new data) on final beat.
//    If res_ready is also high, no overrun.
//    If res_ready is low, the old data is lost and overrun <= 1.
//  res_ready while EMPTY is ignored.
//  clear: acc, cnt, window-sat and overrun <= 0. Any in_valid beat that
//   cycle is discarded. The result buffer and handshake are unaffected.
//  Reset mid-window or mid-drain: everything is lost, no result emitted.
//  in_valid gaps are allowed; the window spans valid beats only.
// TESTING
//  1 Assert reset after 2 of 4 beats -> all outputs 0 at once.
//    After release, 4 new beats -> only those 4 summed.
//  2 Unsigned, K=4, a=1,2,3,4, b=2, contiguous -> res_data=20, res_sat=0.
//    res_valid high the cycle after beat 4. a_out/b_out trail inputs by 1.
//  3 SIGNED=1, K=2, a=-3,-3, b=5,5 -> res_data=-30 sign-extended, res_sat=0.
//  4 SIGNED=1, ACC_WIDTH=16, K=4, a=b=127 ->
//    SATURATE=1: res_data=32767, res_sat=1.
//    SATURATE=0: res_data=64516 (-1020 signed), res_sat=1.
//  5 res_ready=0 over two windows -> second sum replaces first, overrun=1.
//    Repeat with res_ready=1 on the completion cycle -> overrun stays 0.
//  6 clear with in_valid after 2 beats -> beat dropped, cnt restarts.
//    Then 4 beats a=1, b=1 -> res_data=4. Pending res_valid is unaffected.

Source files
------------

// File: rtl/systolic_pe_acc_if.sv
// Operand, forwarding and result-drain signals of one systolic processing element.
// The driver of the element uses master; the element uses slave.
interface systolic_pe_acc_if #(
  parameter int A_WIDTH   = 8,
  parameter int B_WIDTH   = 8,
  parameter int ACC_WIDTH = 24
);
  logic                 clear;
  logic                 in_valid;
  logic [A_WIDTH-1:0]   a_in;
  logic [B_WIDTH-1:0]   b_in;
  logic [A_WIDTH-1:0]   a_out;
  logic [B_WIDTH-1:0]   b_out;
  logic                 out_valid;
  logic                 res_valid;
  logic                 res_ready;
  logic [ACC_WIDTH-1:0] res_data;
  logic                 res_sat;
  logic                 overrun;

  modport master (
    output clear, in_valid, a_in, b_in, res_ready,
    input  a_out, b_out, out_valid, res_valid, res_data, res_sat, overrun
  );

  modport slave (
    input  clear, in_valid, a_in, b_in, res_ready,
    output a_out, b_out, out_valid, res_valid, res_data, res_sat, overrun
  );
endinterface

// File: rtl/systolic_pe_acc.sv
// Systolic PE: forwards a/b east/south, accumulates a*b over K_DEPTH valid beats,
// then hands the window sum to a one-entry result buffer drained by valid/ready.
module systolic_pe_acc #(
  parameter int A_WIDTH   = 8,
  parameter int B_WIDTH   = 8,
  parameter int ACC_WIDTH = 24,
  parameter int K_DEPTH   = 4,
  parameter bit SIGNED    = 1'b0,
  parameter bit SATURATE  = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  systolic_pe_acc_if.slave    bus
);

  localparam int PW    = A_WIDTH + B_WIDTH;
  localparam int EW    = ACC_WIDTH + 1;
  localparam int CNT_W = (K_DEPTH > 1) ? $clog2(K_DEPTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(K_DEPTH - 1);

  typedef enum logic {
    RES_EMPTY,
    RES_FULL
  } res_state_e;

  // Operand forwarding
  logic [A_WIDTH-1:0] a_out_q;
  logic [B_WIDTH-1:0] b_out_q;
  logic               out_valid_q;

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_out_q     <= '0;
      b_out_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      a_out_q     <= bus.a_in;
      b_out_q     <= bus.b_in;
      out_valid_q <= bus.in_valid;
    end
  end

  // Multiply-accumulate datapath
  logic [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  wsat_q, wsat_d;

  logic signed [A_WIDTH:0] a_ext;
  logic signed [B_WIDTH:0] b_ext;
  logic signed [PW+1:0]    prod_full;
  logic signed [EW-1:0]    prod_ext;
  logic signed [EW-1:0]    acc_ext;
  logic signed [EW-1:0]    sum;
  logic                    ovf;
  logic [ACC_WIDTH-1:0]    acc_next;
  logic                    beat;
  logic                    final_beat;

  always_comb begin
    // An extra top bit makes one signed multiply serve both modes.
    a_ext     = {SIGNED & bus.a_in[A_WIDTH-1], bus.a_in};
    b_ext     = {SIGNED & bus.b_in[B_WIDTH-1], b_in_bits()};
    prod_full = a_ext * b_ext;
    prod_ext  = EW'(prod_full);
    acc_ext   = {SIGNED & acc_q[ACC_WIDTH-1], acc_q};
    sum       = acc_ext + prod_ext;
  end

  function automatic logic [B_WIDTH-1:0] b_in_bits();
    return bus.b_in;
  endfunction

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    ovf      = 1'b0;
    acc_next = sum[ACC_WIDTH-1:0];
    if (SIGNED) begin
      ovf = sum[EW-1] ^ sum[EW-2];
    end else begin
      ovf = sum[EW-1];
    end
    if (SATURATE && ovf) begin
      if (SIGNED) begin
        acc_next = sum[EW-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                             : {1'b0, {(ACC_WIDTH-1){1'b1}}};
      end else begin
        acc_next = '1;
      end
    end
  end

  assign beat       = bus.in_valid & ~bus.clear;
  assign final_beat = beat & (cnt_q == LAST_BEAT);

  always_comb begin
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    wsat_d = wsat_q;
    if (bus.clear || final_beat) begin
      acc_d  = '0;
      cnt_d  = '0;
      wsat_d = 1'b0;
    end else if (beat) begin
      acc_d  = acc_next;
      cnt_d  = cnt_q + CNT_W'(1);
      wsat_d = wsat_q | ovf;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      wsat_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      wsat_q <= wsat_d;
    end
  end

  // Result buffer: one entry, a new window sum may land while the old one drains.
  res_state_e           state_q;
  logic                 res_valid_q;
  logic [ACC_WIDTH-1:0] res_data_q;
  logic                 res_sat_q;
  logic                 overrun_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RES_EMPTY;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_sat_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      case (state_q)
        RES_EMPTY: begin
          if (final_beat) begin
            state_q     <= RES_FULL;
            res_valid_q <= 1'b1;
            res_data_q  <= acc_next;
            res_sat_q   <= wsat_q | ovf;
          end
        end
        RES_FULL: begin
          if (final_beat) begin
            res_data_q <= acc_next;
            res_sat_q  <= wsat_q | ovf;
            if (!bus.res_ready) begin
              overrun_q <= 1'b1;
            end
          end else if (bus.res_ready) begin
            state_q     <= RES_EMPTY;
            res_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= RES_EMPTY;
          res_valid_q <= 1'b0;
        end
      endcase
      // A cleared cycle never carries a final beat, so this cannot race the set above.
      if (bus.clear) begin
        overrun_q <= 1'b0;
      end
    end
  end

  assign bus.a_out     = a_out_q;
  assign bus.b_out     = b_out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_sat   = res_sat_q;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_systolic_pe_acc.sv
// Directed bench for systolic_pe_acc: several parameterisations share one stimulus
// stream; each check targets the instance whose configuration it exercises.
module tb_systolic_pe_acc;

  logic       clk = 1'b0;
  logic       rst;
  logic       clear;
  logic       in_valid;
  logic       res_ready;
  logic [7:0] a;
  logic [7:0] b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // u0: unsigned K=4 W=24 wrap   u1: signed K=2 W=24      u2: signed K=4 W=16 sat
  // u3: signed K=4 W=16 wrap     u4: unsigned K=1 W=24    u5: unsigned K=4 W=16 sat
  systolic_pe_acc_if #(.ACC_WIDTH(24)) if0 ();
  systolic_pe_acc_if #(.ACC_WIDTH(24)) if1 ();
  systolic_pe_acc_if #(.ACC_WIDTH(16)) if2 ();
  systolic_pe_acc_if #(.ACC_WIDTH(16)) if3 ();
  systolic_pe_acc_if #(.ACC_WIDTH(24)) if4 ();
  systolic_pe_acc_if #(.ACC_WIDTH(16)) if5 ();

  assign if0.clear = clear; assign if0.in_valid = in_valid; assign if0.a_in = a; assign if0.b_in = b; assign if0.res_ready = res_ready;
  assign if1.clear = clear; assign if1.in_valid = in_valid; assign if1.a_in = a; assign if1.b_in = b; assign if1.res_ready = res_ready;
  assign if2.clear = clear; assign if2.in_valid = in_valid; assign if2.a_in = a; assign if2.b_in = b; assign if2.res_ready = res_ready;
  assign if3.clear = clear; assign if3.in_valid = in_valid; assign if3.a_in = a; assign if3.b_in = b; assign if3.res_ready = res_ready;
  assign if4.clear = clear; assign if4.in_valid = in_valid; assign if4.a_in = a; assign if4.b_in = b; assign if4.res_ready = res_ready;
  assign if5.clear = clear; assign if5.in_valid = in_valid; assign if5.a_in = a; assign if5.b_in = b; assign if5.res_ready = res_ready;

  systolic_pe_acc #(.ACC_WIDTH(24), .K_DEPTH(4), .SIGNED(1'b0), .SATURATE(1'b0))
    u0 (.clk(clk), .rst(rst), .bus(if0));
  systolic_pe_acc #(.ACC_WIDTH(24), .K_DEPTH(2), .SIGNED(1'b1), .SATURATE(1'b0))
    u1 (.clk(clk), .rst(rst), .bus(if1));
  systolic_pe_acc #(.ACC_WIDTH(16), .K_DEPTH(4), .SIGNED(1'b1), .SATURATE(1'b1))
    u2 (.clk(clk), .rst(rst), .bus(if2));
  systolic_pe_acc #(.ACC_WIDTH(16), .K_DEPTH(4), .SIGNED(1'b1), .SATURATE(1'b0))
    u3 (.clk(clk), .rst(rst), .bus(if3));
  systolic_pe_acc #(.ACC_WIDTH(24), .K_DEPTH(1), .SIGNED(1'b0), .SATURATE(1'b0))
    u4 (.clk(clk), .rst(rst), .bus(if4));
  systolic_pe_acc #(.ACC_WIDTH(16), .K_DEPTH(4), .SIGNED(1'b0), .SATURATE(1'b1))
    u5 (.clk(clk), .rst(rst), .bus(if5));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs, then land 1 time unit after the sampling edge.
  task automatic step(input logic v, input logic [7:0] av, input logic [7:0] bv,
                      input logic clr, input logic rdy);
    in_valid  = v;
    a         = av;
    b         = bv;
    clear     = clr;
    res_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; res_ready = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_res_valid", 32'(if0.res_valid), 32'd0);
    check("rst_a_out",     32'(if0.a_out),     32'd0);
    rst = 1'b0;

    // Two beats, then an asynchronous reset mid-window.
    step(1'b1, 8'd9, 8'd9, 1'b0, 1'b0);
    check("fwd_a_out",     32'(if0.a_out),     32'd9);
    check("fwd_out_valid", 32'(if0.out_valid), 32'd1);
    step(1'b1, 8'd9, 8'd9, 1'b0, 1'b0);
    check("k1_data_pre_rst", 32'(if4.res_data), 32'd81);
    #2 rst = 1'b1;
    #1;
    check("arst_a_out",     32'(if0.a_out),     32'd0);
    check("arst_out_valid", 32'(if0.out_valid), 32'd0);
    check("arst_k1_valid",  32'(if4.res_valid), 32'd0);
    check("arst_k1_data",   32'(if4.res_data),  32'd0);
    in_valid = 1'b0;
    #2 rst = 1'b0;

    // Unsigned window a=1..4, b=2: only post-reset beats count.
    step(1'b1, 8'd1, 8'd2, 1'b0, 1'b0);
    check("fwd_b_out", 32'(if0.b_out), 32'd2);
    step(1'b1, 8'd2, 8'd2, 1'b0, 1'b0);
    step(1'b1, 8'd3, 8'd2, 1'b0, 1'b0);
    check("k4_not_yet", 32'(if0.res_valid), 32'd0);
    check("fwd_a_lag",  32'(if0.a_out),     32'd3);
    step(1'b1, 8'd4, 8'd2, 1'b0, 1'b0);
    check("k4_valid", 32'(if0.res_valid), 32'd1);
    check("k4_data",  32'(if0.res_data),  32'd20);
    check("k4_sat",   32'(if0.res_sat),   32'd0);
    check("k1_data",  32'(if4.res_data),  32'd8);
    step(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
    check("hold_valid",     32'(if0.res_valid), 32'd1);
    check("out_valid_idle", 32'(if0.out_valid), 32'd0);

    // Second window lands on an undrained result: overrun.
    for (int i = 0; i < 4; i++) step(1'b1, 8'd1, 8'd1, 1'b0, 1'b0);
    check("ovr_data",    32'(if0.res_data),  32'd4);
    check("ovr_valid",   32'(if0.res_valid), 32'd1);
    check("ovr_overrun", 32'(if0.overrun),   32'd1);
    step(1'b0, 8'd0, 8'd0, 1'b0, 1'b1);
    check("drain_valid",    32'(if0.res_valid), 32'd0);
    check("overrun_sticky", 32'(if0.overrun),   32'd1);
    step(1'b0, 8'd0, 8'd0, 1'b0, 1'b1);
    check("ready_when_empty", 32'(if0.res_valid), 32'd0);
    step(1'b0, 8'd0, 8'd0, 1'b1, 1'b0);
    check("clear_overrun", 32'(if0.overrun), 32'd0);

    // Completion coinciding with res_ready: no overrun.
    for (int i = 0; i < 4; i++) step(1'b1, 8'd1, 8'd1, 1'b0, 1'b0);
    check("fill_data", 32'(if0.res_data), 32'd4);
    for (int i = 0; i < 3; i++) step(1'b1, 8'd2, 8'd1, 1'b0, 1'b0);
    step(1'b1, 8'd2, 8'd1, 1'b0, 1'b1);
    check("ready_on_done_data",    32'(if0.res_data),  32'd8);
    check("ready_on_done_valid",   32'(if0.res_valid), 32'd1);
    check("ready_on_done_overrun", 32'(if0.overrun),   32'd0);

    // Clear after two beats drops the concurrent beat and restarts the count.
    step(1'b1, 8'd5, 8'd5, 1'b0, 1'b0);
    step(1'b1, 8'd5, 8'd5, 1'b0, 1'b0);
    step(1'b1, 8'd7, 8'd7, 1'b1, 1'b0);
    check("clear_keeps_valid", 32'(if0.res_valid), 32'd1);
    check("clear_keeps_data",  32'(if0.res_data),  32'd8);
    check("clear_fwd_a",       32'(if0.a_out),     32'd7);
    step(1'b1, 8'd1, 8'd1, 1'b0, 1'b0);
    step(1'b1, 8'd1, 8'd1, 1'b0, 1'b0);
    step(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
    step(1'b1, 8'd1, 8'd1, 1'b0, 1'b0);
    check("cnt_restart_hold", 32'(if0.res_data), 32'd8);
    step(1'b1, 8'd1, 8'd1, 1'b0, 1'b0);
    check("clear_window_data",    32'(if0.res_data), 32'd4);
    check("clear_window_overrun", 32'(if0.overrun),  32'd1);

    // Signed K=2: (-3*5) + (-3*5) = -30.
    step(1'b0, 8'd0, 8'd0, 1'b1, 1'b0);
    step(1'b1, 8'hFD, 8'd5, 1'b0, 1'b0);
    step(1'b1, 8'hFD, 8'd5, 1'b0, 1'b0);
    check("signed_valid", 32'(if1.res_valid), 32'd1);
    check("signed_data",  32'(if1.res_data),  32'hFF_FFE2);
    check("signed_sat",   32'(if1.res_sat),   32'd0);

    // 4 x 127*127 = 64516: past the signed 16-bit range.
    step(1'b0, 8'd0, 8'd0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 8'd127, 8'd127, 1'b0, 1'b0);
    check("ssat_data",   32'(if2.res_data), 32'h7FFF);
    check("ssat_flag",   32'(if2.res_sat),  32'd1);
    check("swrap_data",  32'(if3.res_data), 32'hFC04);
    check("swrap_flag",  32'(if3.res_sat),  32'd1);
    check("u24_data",    32'(if0.res_data), 32'd64516);
    check("u16sat_data", 32'(if5.res_data), 32'd64516);
    check("u16sat_flag", 32'(if5.res_sat),  32'd0);

    // 4 x 255*255: unsigned clamps; signed sees (-1)*(-1).
    step(1'b0, 8'd0, 8'd0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 8'd255, 8'd255, 1'b0, 1'b0);
    check("usat_data",       32'(if5.res_data), 32'hFFFF);
    check("usat_flag",       32'(if5.res_sat),  32'd1);
    check("sneg_data",       32'(if3.res_data), 32'd4);
    check("sat_flag_clears", 32'(if2.res_sat),  32'd0);
    check("u24_big_data",    32'(if0.res_data), 32'h3F804);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
